// File: rtl/arbitro_nos_ativos.sv
// Round-robin arbiter/sequencer sharing the active-node manager among NUM_REQ requesters.
// Optional wait timeout enabled by defining ARBITRO_TIMEOUT_EN.
module arbitro_nos_ativos #(
  parameter int NUM_REQ       = 4,
  parameter int NUM_NA        = 8,
  parameter int ADR_WIDTH     = 5,
  parameter int TIMEOUT_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid_in,
  input  logic [NUM_REQ-1:0]             req_op_in,
  input  logic [ADR_WIDTH*NUM_REQ-1:0]   req_endereco_in,
  output logic [NUM_REQ-1:0]             req_ready_out,
  output logic [NUM_REQ-1:0]             resp_valid_out,
  output logic [NUM_NA-1:0]              resp_slot_out,
  output logic                           resp_ok_out,
  output logic                           ocupado_out,
  output logic                           ger_atualizar_out,
  output logic                           ger_desativar_out,
  output logic [ADR_WIDTH-1:0]           ger_endereco_out,
  input  logic                           ger_done_in,
  input  logic [NUM_NA-1:0]              ger_habilitar_in
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  if (NUM_REQ < 2 || TIMEOUT_WIDTH < 1) begin : g_param_check
    $error("arbitro_nos_ativos: NUM_REQ must be >= 2 and TIMEOUT_WIDTH >= 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_EMITE, ST_ESPERA, ST_RESPONDE} state_t;

  state_t                 state_q;
  logic [IDX_W-1:0]       g_q;
  logic [IDX_W-1:0]       ultimo_q;
  logic                   op_q;
  logic [ADR_WIDTH-1:0]   end_q;
  logic [NUM_NA-1:0]      slot_q;
  logic [NUM_REQ-1:0]     req_ready_q;
  logic [NUM_REQ-1:0]     resp_valid_q;
  logic [NUM_NA-1:0]      resp_slot_q;
  logic                   resp_ok_q;
  logic                   ocupado_q;
  logic                   ger_atu_q;
  logic                   ger_des_q;
`ifdef ARBITRO_TIMEOUT_EN
  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_MAX = '1;
  logic [TIMEOUT_WIDTH-1:0] timer_q;
`endif

  logic             gnt_found_d;
  logic [IDX_W-1:0] gnt_d;

  // Scan ultimo+1, ultimo+2, ... so the last served requester gets lowest priority.
  always_comb begin
    int unsigned k;
    gnt_found_d = 1'b0;
    gnt_d       = '0;
    k           = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      k = (32'(ultimo_q) + i) % NUM_REQ;
      if (!gnt_found_d && req_valid_in[IDX_W'(k)]) begin
        gnt_found_d = 1'b1;
        gnt_d       = IDX_W'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      g_q          <= '0;
      ultimo_q     <= IDX_W'(NUM_REQ - 1);
      op_q         <= 1'b0;
      end_q        <= '0;
      slot_q       <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_slot_q  <= '0;
      resp_ok_q    <= 1'b0;
      ocupado_q    <= 1'b0;
      ger_atu_q    <= 1'b0;
      ger_des_q    <= 1'b0;
`ifdef ARBITRO_TIMEOUT_EN
      timer_q      <= '0;
`endif
    end else begin
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_slot_q  <= '0;
      resp_ok_q    <= 1'b0;
      ger_atu_q    <= 1'b0;
      ger_des_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_found_d) begin
            g_q         <= gnt_d;
            op_q        <= req_op_in[gnt_d];
            end_q       <= req_endereco_in[ADR_WIDTH*gnt_d +: ADR_WIDTH];
            req_ready_q <= ONE_HOT0 << gnt_d;
            ger_atu_q   <= !req_op_in[gnt_d];
            ger_des_q   <= req_op_in[gnt_d];
            ocupado_q   <= 1'b1;
            state_q     <= ST_EMITE;
          end
        end
        ST_EMITE: begin
`ifdef ARBITRO_TIMEOUT_EN
          timer_q <= '0;
`endif
          state_q <= ST_ESPERA;
        end
        ST_ESPERA: begin
          // Done is checked before the timeout so a coinciding done still wins.
          if (ger_done_in) begin
            slot_q       <= ger_habilitar_in;
            resp_valid_q <= ONE_HOT0 << g_q;
            resp_slot_q  <= ger_habilitar_in;
            resp_ok_q    <= |ger_habilitar_in;
            state_q      <= ST_RESPONDE;
          end
`ifdef ARBITRO_TIMEOUT_EN
          else if (timer_q == TIMER_MAX) begin
            slot_q       <= '0;
            resp_valid_q <= ONE_HOT0 << g_q;
            state_q      <= ST_RESPONDE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
`endif
        end
        ST_RESPONDE: begin
          ultimo_q  <= g_q;
          ocupado_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_out     = req_ready_q;
  assign resp_valid_out    = resp_valid_q;
  assign resp_slot_out     = resp_slot_q;
  assign resp_ok_out       = resp_ok_q;
  assign ocupado_out       = ocupado_q;
  assign ger_atualizar_out = ger_atu_q;
  assign ger_desativar_out = ger_des_q;
  assign ger_endereco_out  = end_q;

endmodule
